// File: rtl/core_pkg.sv
// Shared RV32I core definitions: datapath width, writeback select, load funct3 codes
// and the MEM/WB slot payload.
package core_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Contents of the MEM/WB pipeline register
  typedef struct packed {
    logic            valid;
    logic            rd_wren;
    logic [4:0]      rd_addr;
    logic [1:0]      wb_sel;
    logic [2:0]      funct3;
    logic [1:0]      addr_lsb;
    logic [XLEN-1:0] alu_data;
    logic [XLEN-1:0] ld_raw;
    logic [XLEN-1:0] pc_plus4;
  } mem_wb_t;

endpackage

// File: rtl/load_extend.sv
// Load data extraction: picks the addressed byte/halfword from an aligned little-endian
// word and sign/zero-extends it according to funct3. Also used by the forwarding path.
module load_extend
  import core_pkg::*;
(
  input  logic [XLEN-1:0] raw_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lsb_i,
  output logic [XLEN-1:0] ext_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane select then extension; unsupported funct3 yields zero
  always_comb begin
    byte_v = raw_i[{addr_lsb_i, 3'b000} +: 8];
    half_v = addr_lsb_i[1] ? raw_i[31:16] : raw_i[15:0];
    ext_o  = '0;
    case (funct3_i)
      F3_LB:   ext_o = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_LBU:  ext_o = {{(XLEN-8){1'b0}}, byte_v};
      F3_LH:   ext_o = {{(XLEN-16){half_v[15]}}, half_v};
      F3_LHU:  ext_o = {{(XLEN-16){1'b0}}, half_v};
      F3_LW:   ext_o = raw_i;
      default: ext_o = '0;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback mux driving the register file write port.
// Optional: define WB_RETIRE_CNT_EN to add a 64-bit retired-instruction counter.
module wb_stage
  import core_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_stall,
  input  logic            i_flush,
  input  logic            i_valid,
  input  logic            i_rd_wren,
  input  logic [4:0]      i_rd_addr,
  input  logic [1:0]      i_wb_sel,
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addr_lsb,
  input  logic [XLEN-1:0] i_alu_data,
  input  logic [XLEN-1:0] i_ld_raw,
  input  logic [XLEN-1:0] i_pc_plus4,
  output logic            o_rd_wren,
  output logic [4:0]      o_rd_addr,
  output logic [XLEN-1:0] o_rd_data,
  output logic            o_wb_valid
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]     o_retire_cnt
`endif
);

  mem_wb_t         slot_d, slot_q;
  logic [XLEN-1:0] ld_ext;

  // Slot next state: flush beats stall, stall beats capture
  always_comb begin
    slot_d = slot_q;
    if (i_flush) begin
      slot_d.valid = 1'b0;
    end else if (!i_stall) begin
      slot_d.valid    = i_valid;
      slot_d.rd_wren  = i_rd_wren;
      slot_d.rd_addr  = i_rd_addr;
      slot_d.wb_sel   = i_wb_sel;
      slot_d.funct3   = i_funct3;
      slot_d.addr_lsb = i_addr_lsb;
      slot_d.alu_data = i_alu_data;
      slot_d.ld_raw   = i_ld_raw;
      slot_d.pc_plus4 = i_pc_plus4;
    end
  end

  // MEM/WB register; reset drops the in-flight entry immediately
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) slot_q <= '0;
    else       slot_q <= slot_d;
  end

  load_extend u_load_extend (
    .raw_i      (slot_q.ld_raw),
    .funct3_i   (slot_q.funct3),
    .addr_lsb_i (slot_q.addr_lsb),
    .ext_o      (ld_ext)
  );

  // Write triple from the registered slot; x0 writes are suppressed
  always_comb begin
    o_wb_valid = slot_q.valid;
    o_rd_wren  = slot_q.valid & slot_q.rd_wren & (slot_q.rd_addr != 5'd0);
    o_rd_addr  = slot_q.valid ? slot_q.rd_addr : 5'd0;
    o_rd_data  = '0;
    if (slot_q.valid) begin
      case (slot_q.wb_sel)
        WB_ALU:  o_rd_data = slot_q.alu_data;
        WB_LOAD: o_rd_data = ld_ext;
        WB_PC4:  o_rd_data = slot_q.pc_plus4;
        default: o_rd_data = '0;
      endcase
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt_d, retire_cnt_q;

  // Count an instruction once, on the edge where it leaves the stage
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (slot_q.valid && (!i_stall || i_flush)) retire_cnt_d = retire_cnt_q + 64'd1;
  end

  // Retire counter register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) retire_cnt_q <= '0;
    else       retire_cnt_q <= retire_cnt_d;
  end

  assign o_retire_cnt = retire_cnt_q;
`endif

endmodule
